// File: rtl/matrix_inv_pkg.sv
// ============================================================================
// Module      : matrix_inv_pkg
// Description : Shared types and constants for the matrix-inversion datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_inv_pkg;

    localparam int WORDLEN        = 16;
    localparam int FRACTION_WIDTH = 12;
    localparam int MATRIX_DIM     = 3;
    localparam int ACC_WIDTH      = 2 * WORDLEN + $clog2(MATRIX_DIM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef logic signed [WORDLEN-1:0]   fxp_word_t;
    typedef logic signed [ACC_WIDTH-1:0] fxp_acc_t;

endpackage

`default_nettype wire

// File: rtl/fxp_scale_sat.sv
// ============================================================================
// Module      : fxp_scale_sat
// Description : Drops FRAC_WIDTH fraction bits (floor) and reduces to OUT_WIDTH,
//               saturating when QT_MAC_SAT_EN is defined, wrapping otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fxp_scale_sat
    import matrix_inv_pkg::*;
#(
    parameter int IN_WIDTH   = matrix_inv_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = matrix_inv_pkg::WORDLEN,
    parameter int FRAC_WIDTH = matrix_inv_pkg::FRACTION_WIDTH
) (
    input  logic signed [IN_WIDTH-1:0]  acc_in,
    output logic        [OUT_WIDTH-1:0] result_out
);

    // Bit index just above the retained result window.
    localparam int HI = FRAC_WIDTH + OUT_WIDTH;

    logic [FRAC_WIDTH-1:0] w_unused_frac;
    assign w_unused_frac = acc_in[FRAC_WIDTH-1:0];

`ifdef QT_MAC_SAT_EN
    // The result sign bit and everything above it must agree for the value to fit.
    logic [IN_WIDTH-HI:0] w_upper;
    logic                 w_fits;

    assign w_upper    = acc_in[IN_WIDTH-1:HI-1];
    assign w_fits     = (&w_upper) | ~(|w_upper);
    assign result_out = w_fits          ? acc_in[FRAC_WIDTH +: OUT_WIDTH] :
                        acc_in[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                             {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
    logic [IN_WIDTH-HI-1:0] w_unused_hi;

    assign w_unused_hi = acc_in[IN_WIDTH-1:HI];
    assign result_out  = acc_in[FRAC_WIDTH +: OUT_WIDTH];
`endif

endmodule

`default_nettype wire

// File: rtl/qt_vector_mac.sv
// ============================================================================
// Module      : qt_vector_mac
// Description : Streams Q^T row-major and produces c = Q^T * b one row at a time.
//               Build macro QT_MAC_SAT_EN selects saturating output reduction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qt_vector_mac
    import matrix_inv_pkg::*;
#(
    parameter int WORDLEN            = matrix_inv_pkg::WORDLEN,
    parameter int FRACTION_WIDTH     = matrix_inv_pkg::FRACTION_WIDTH,
    parameter int MATRIX_DIM         = matrix_inv_pkg::MATRIX_DIM,
    parameter int MATRIX_ELEMENT_NUM = MATRIX_DIM * MATRIX_DIM
) (
    input  logic                              CLK,
    input  logic                              RST_n,
    input  logic                              vec_load,
    input  logic [MATRIX_DIM*WORDLEN-1:0]     vec_in,
    input  logic                              element_valid,
    input  logic [WORDLEN-1:0]                element_in,
    output logic [WORDLEN-1:0]                result_out,
    output logic                              result_valid,
    output logic [$clog2(MATRIX_DIM)-1:0]     result_row,
    output logic                              done,
    output logic                              busy
);

    localparam int ACC_W  = 2 * WORDLEN + $clog2(MATRIX_DIM);
    localparam int IDX_W  = $clog2(MATRIX_DIM);
    localparam int ELEM_W = $clog2(MATRIX_ELEMENT_NUM);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MATRIX_DIM - 1);
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(MATRIX_ELEMENT_NUM - 1);

    state_t                          state_q, state_d;
    logic [MATRIX_DIM*WORDLEN-1:0]   vec_q, vec_d;
    logic [IDX_W-1:0]                col_q, col_d;
    logic [IDX_W-1:0]                row_q, row_d;
    logic [ELEM_W-1:0]               elem_q, elem_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic [WORDLEN-1:0]              result_q, result_d;
    logic [IDX_W-1:0]                res_row_q, res_row_d;
    logic                            valid_q, valid_d;
    logic                            done_q, done_d;

    logic signed [WORDLEN-1:0]       b_arr [MATRIX_DIM];
    logic signed [WORDLEN-1:0]       w_b_sel;
    logic signed [2*WORDLEN-1:0]     w_elem_x, w_b_x, w_prod;
    logic signed [ACC_W-1:0]         w_prod_x, w_acc_base, w_sum;
    logic [WORDLEN-1:0]              w_scaled;
    logic                            w_accept;

    for (genvar gi = 0; gi < MATRIX_DIM; gi++) begin : g_unpack_b
        assign b_arr[gi] = vec_q[gi*WORDLEN +: WORDLEN];
    end

    assign w_b_sel    = b_arr[col_q];
    assign w_elem_x   = {{WORDLEN{element_in[WORDLEN-1]}}, element_in};
    assign w_b_x      = {{WORDLEN{w_b_sel[WORDLEN-1]}}, w_b_sel};
    assign w_prod     = w_elem_x * w_b_x;
    assign w_prod_x   = {{(ACC_W-2*WORDLEN){w_prod[2*WORDLEN-1]}}, w_prod};
    // Column 0 starts a fresh row sum rather than adding onto the previous row.
    assign w_acc_base = (col_q == '0) ? '0 : acc_q;
    assign w_sum      = w_acc_base + w_prod_x;
    assign w_accept   = element_valid && ((state_q == READY) || (state_q == RUN));

    fxp_scale_sat #(
        .IN_WIDTH   (ACC_W),
        .OUT_WIDTH  (WORDLEN),
        .FRAC_WIDTH (FRACTION_WIDTH)
    ) u_scale (
        .acc_in     (w_sum),
        .result_out (w_scaled)
    );

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        col_d     = col_q;
        row_d     = row_q;
        elem_d    = elem_q;
        acc_d     = acc_q;
        result_d  = result_q;
        res_row_d = res_row_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (vec_load) begin
                    vec_d   = vec_in;
                    state_d = READY;
                end
            end
            READY: begin
                if (vec_load) begin
                    vec_d = vec_in;
                end
            end
            default: ;
        endcase

        if (w_accept) begin
            state_d = RUN;
            acc_d   = w_sum;
            col_d   = col_q + 1'b1;
            elem_d  = elem_q + 1'b1;
            if (col_q == LAST_IDX) begin
                col_d     = '0;
                row_d     = row_q + 1'b1;
                acc_d     = '0;
                result_d  = w_scaled;
                res_row_d = row_q;
                valid_d   = 1'b1;
            end
            if (elem_q == LAST_ELEM) begin
                state_d = READY;
                row_d   = '0;
                elem_d  = '0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            elem_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            res_row_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            col_q     <= col_d;
            row_q     <= row_d;
            elem_q    <= elem_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            res_row_q <= res_row_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign result_out   = result_q;
    assign result_row   = res_row_q;
    assign result_valid = valid_q;
    assign done         = done_q;
    assign busy         = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_qt_vector_mac.sv
// ============================================================================
// Module      : tb_qt_vector_mac
// Description : Self-checking bench for qt_vector_mac against a row-sum model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qt_vector_mac;

    localparam int W    = 16;
    localparam int DIM  = 3;
    localparam int NEL  = 9;
    localparam int FRAC = 12;

    typedef logic [W-1:0] mat_t [NEL];
    typedef logic [W-1:0] vec_t [DIM];

    logic             CLK = 1'b0;
    logic             RST_n = 1'b0;
    logic             vec_load = 1'b0;
    logic [DIM*W-1:0] vec_in = '0;
    logic             element_valid = 1'b0;
    logic [W-1:0]     element_in = '0;
    logic [W-1:0]     result_out;
    logic             result_valid;
    logic [1:0]       result_row;
    logic             done;
    logic             busy;

    int         errors = 0;
    int         checks = 0;
    vec_t       model_b;
    bit         model_has_vec = 1'b0;
    logic [W-1:0] last_res = '0;
    logic [1:0]   last_row = '0;

    always #5 CLK = ~CLK;

    qt_vector_mac dut (
        .CLK           (CLK),
        .RST_n         (RST_n),
        .vec_load      (vec_load),
        .vec_in        (vec_in),
        .element_valid (element_valid),
        .element_in    (element_in),
        .result_out    (result_out),
        .result_valid  (result_valid),
        .result_row    (result_row),
        .done          (done),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // c[r] = floor(sum_c m[r][c]*b[c] / 2^FRAC), then reduced to W bits.
    function automatic logic [W-1:0] model_row(input mat_t m, input vec_t b, input int r);
        longint acc;
        acc = 0;
        for (int c = 0; c < DIM; c++)
            acc += longint'($signed(m[r*DIM+c])) * longint'($signed(b[c]));
        acc = acc >>> FRAC;
`ifdef QT_MAC_SAT_EN
        if (acc > 32767)       acc = 32767;
        else if (acc < -32768) acc = -32768;
`endif
        return acc[W-1:0];
    endfunction

    task automatic drive_vec(input vec_t b);
        for (int c = 0; c < DIM; c++) vec_in[c*W +: W] = b[c];
    endtask

    task automatic load_vec(input vec_t b);
        vec_load = 1'b1;
        drive_vec(b);
        tick();
        vec_load = 1'b0;
        model_b = b;
        model_has_vec = 1'b1;
        check("load_no_result", {31'd0, result_valid}, 32'd0);
        check("load_not_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_quiet(input bit exp_busy);
        check("no_result_valid", {31'd0, result_valid}, 32'd0);
        check("no_done", {31'd0, done}, 32'd0);
        check("hold_out", {16'd0, result_out}, {16'd0, last_res});
        check("hold_row", {30'd0, result_row}, {30'd0, last_row});
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
    endtask

    // gap_mode: 0 none, 1 one idle cycle after each element, 2 random 0..3.
    task automatic run_matrix(input mat_t m, input int n, input int gap_mode,
                              input int mid_load_at, input vec_t mid_b);
        bit           exp_on;
        int           gaps;
        logic [W-1:0] e;
        exp_on = model_has_vec;
        for (int i = 0; i < n; i++) begin
            element_valid = 1'b1;
            element_in    = m[i];
            tick();
            element_valid = 1'b0;
            if (exp_on && (i % DIM) == DIM - 1) begin
                e = model_row(m, model_b, i / DIM);
                check("result_valid", {31'd0, result_valid}, 32'd1);
                check("result_out", {16'd0, result_out}, {16'd0, e});
                check("result_row", {30'd0, result_row}, 32'(i / DIM));
                check("done", {31'd0, done}, {31'd0, (i == NEL - 1)});
                check("busy", {31'd0, busy}, {31'd0, (i != NEL - 1)});
                last_res = e;
                last_row = 2'(i / DIM);
            end else begin
                check_quiet(exp_on);
            end
            if (i != n - 1) begin
                gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
                if (i == mid_load_at && gaps == 0) gaps = 1;
                for (int g = 0; g < gaps; g++) begin
                    if (i == mid_load_at && g == 0) begin
                        vec_load = 1'b1;
                        drive_vec(mid_b);
                    end
                    tick();
                    vec_load = 1'b0;
                    check_quiet(exp_on);
                end
            end
        end
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        #2;
        model_has_vec = 1'b0;
        last_res = '0;
        last_row = '0;
        check("rst_out", {16'd0, result_out}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_row", {30'd0, result_row}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        tick();
        check_quiet(1'b0);
    endtask

    mat_t ident   = '{16'h1000, 16'h0000, 16'h0000,
                      16'h0000, 16'h1000, 16'h0000,
                      16'h0000, 16'h0000, 16'h1000};
    mat_t signm   = '{16'hF000, 16'h0000, 16'h0000,
                      16'h0800, 16'h0800, 16'h0000,
                      16'h0000, 16'h0000, 16'h1000};
    mat_t uni     = '{default: 16'h0800};
    mat_t big     = '{default: 16'h7FFF};
    vec_t b_id    = '{16'h04CD, 16'h0333, 16'h0666};
    vec_t b_one   = '{default: 16'h1000};
    vec_t b_sign  = '{16'h1000, 16'hE000, 16'h0800};
    vec_t b_big   = '{default: 16'h7FFF};

    initial begin
        mat_t rm;
        vec_t rb, rb2;

        #12;
        check("init_out", {16'd0, result_out}, 32'd0);
        check("init_valid", {31'd0, result_valid}, 32'd0);
        check("init_row", {30'd0, result_row}, 32'd0);
        check("init_done", {31'd0, done}, 32'd0);
        check("init_busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        tick();

        // Elements with no vector held must be ignored.
        run_matrix(ident, NEL, 0, -1, b_id);

        // Identity, then a second identity back-to-back reusing b.
        load_vec(b_id);
        run_matrix(ident, NEL, 0, -1, b_id);
        run_matrix(ident, NEL, 0, -1, b_id);
        tick();
        check_quiet(1'b0);

        load_vec(b_one);
        run_matrix(uni, NEL, 1, -1, b_one);

        load_vec(b_sign);
        run_matrix(signm, NEL, 2, -1, b_sign);

        load_vec(b_big);
        run_matrix(big, NEL, 0, -1, b_big);

        // vec_load mid-stream must not disturb this or the following matrix.
        for (int k = 0; k < NEL; k++) rm[k] = W'($urandom);
        for (int c = 0; c < DIM; c++) begin
            rb[c]  = W'($urandom);
            rb2[c] = W'($urandom);
        end
        load_vec(rb);
        run_matrix(rm, NEL, 0, 4, rb2);
        run_matrix(rm, NEL, 2, -1, rb);

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < NEL; k++) rm[k] = W'($urandom);
            for (int c = 0; c < DIM; c++) rb[c] = W'($urandom);
            load_vec(rb);
            run_matrix(rm, NEL, 2, -1, rb);
        end

        // Reset after a partial matrix drops the vector.
        load_vec(b_id);
        run_matrix(ident, 4, 0, -1, b_id);
        do_reset();
        run_matrix(ident, NEL, 0, -1, b_id);
        load_vec(b_sign);
        run_matrix(signm, NEL, 0, -1, b_sign);
        tick();
        check_quiet(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qt_vector_mac.md
Name: qt_vector_mac

Overview:
- Receiving end of the Q-transpose serial stream. Consumes the 9 Q^T elements, emitted one per valid cycle in row-major order, and multiplies them on the fly by a latched 3-element vector b.
- Emits c = Q^T·b one row result at a time. c feeds the back-substitution stage that solves R·x = Q^T·b.
- All data is signed fixed point with FRACTION_WIDTH fraction bits (Q4.12 at defaults).

Parameters:
- WORDLEN, 16, width of every data word.
- FRACTION_WIDTH, 12, number of fraction bits in each word.
- MATRIX_DIM, 3, rows/columns of Q^T.
- MATRIX_ELEMENT_NUM, 9, must equal MATRIX_DIM*MATRIX_DIM.

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- vec_load  in  1  one-cycle pulse that latches vec_in.
- vec_in  in  MATRIX_DIM*WORDLEN  packed b; b[0] sits in the LSBs.
- element_valid  in  1  element_in is valid this cycle.
- element_in  in  WORDLEN  serial Q^T element, row-major.
- result_out  out  WORDLEN  c[row], Q4.12.
- result_valid  out  1  one-cycle pulse per row result.
- result_row  out  $clog2(MATRIX_DIM)  row index of result_out.
- done  out  1  pulse coincident with the last row's result_valid.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (async, RST_n=0): state IDLE, counters 0, accumulator 0, vector register 0, all outputs 0.
- States and transitions:
  - IDLE: no vector held. vec_load goes to READY. element_valid is ignored.
  - READY: vector held. vec_load replaces the vector and stays in READY. element_valid goes to RUN, and that element is accumulated as col 0 of row 0.
  - RUN: each element_valid sample accumulates element_in*b[col] and increments col.
    - When col wraps (MATRIX_DIM-1 to 0), the row result is produced and row increments.
    - After the last element (row MATRIX_DIM-1, col MATRIX_DIM-1), return to READY. The vector is retained for reuse.
- vec_load during RUN: ignored. vec_load during reset: ignored.
- Arithmetic:
  - Each product is a signed 2*WORDLEN multiply.
  - Accumulator width is 2*WORDLEN+$clog2(MATRIX_DIM). It is cleared at the start of each row.
  - Row result = accumulator arithmetic-shifted right by FRACTION_WIDTH (floor, no rounding), then reduced to WORDLEN (see Optional Feature).
- Latency: result_out, result_row and result_valid are registered. They are valid the cycle after the row's last element is sampled.
- Output hold: result_out and result_row hold until the next result. result_valid and done are single-cycle pulses.
- Gaps: element_valid gaps of any length are allowed mid-row. No timeout.
- Back-to-back: element_valid may arrive in the same cycle done pulses. That cycle is in READY, so the element starts a new matrix.
- Reset mid-RUN: partial row is discarded and the state returns to IDLE. The vector must be reloaded.

Optional Feature:
- Macro: QT_MAC_SAT_EN.
- Defined: the shifted result saturates to [-2^(WORDLEN-1), 2^(WORDLEN-1)-1], i.e. 0x8000..0x7FFF at defaults.
- Undefined: the shifted result is truncated to its low WORDLEN bits (wraps).

Decomposition:
- Shared package (matrix_inv_pkg) holds:
  - state enum {IDLE, READY, RUN};
  - WORDLEN, FRACTION_WIDTH, MATRIX_DIM constants;
  - typedef for a signed fixed-point word;
  - typedef for the wide accumulator.
- One natural sub-module, fxp_scale_sat: shift right by FRACTION_WIDTH plus the saturate/wrap reduction, combinational, with behaviour selected by QT_MAC_SAT_EN.

Test Plan:
- Identity: reset; vec_load b=(0x04CD,0x0333,0x0666); stream Q^T=identity (0x1000 on the diagonal, 0 elsewhere), one element per cycle. Expect result_valid rows 0,1,2 with 0x04CD, 0x0333, 0x0666; done with row 2; busy low after.
- Uniform with gaps: b=(0x1000,0x1000,0x1000); all elements 0x0800; element_valid toggling 1/0 as in the Q-transpose handshake. Expect three results of 0x1800, each 1 cycle after its row's 3rd element.
- Sign: row 0 = (0xF000,0,0), b[0]=0x1000. Expect c[0]=0xF000. Row 1 = (0x0800,0x0800,0), b=(0x1000,0xE000,-). Expect c[1]=0xF800.
- Overflow: all elements 0x7FFF, b all 0x7FFF.
  - With QT_MAC_SAT_EN: every result is 0x7FFF.
  - Without it: every result is 0xFFD0.
- Control corners:
  - element_valid in IDLE produces no response.
  - vec_load mid-RUN is ignored; results use the old b.
  - RST_n pulsed low after 4 elements: all outputs 0, state IDLE; a following stream without vec_load gives no results.
- Reuse: after done, stream a second identity matrix without vec_load. Expect the same three results, with no idle cycle needed between matrices.
